instr_encoder: RTL and testbench
================================

# instr_encoder

Inverse of the decode stage: accepts operation descriptors in the decoder's format (17-bit operation id plus register indices and immediate) and encodes them into RV32IM instruction words. Words are buffered in a FIFO and emitted as 3-wide fetch bundles with a running PC, matching what the 3-wide front end consumes. Used as the program source for the decoder in self-checking benches and as the instruction-memory preload path.

## Interface
- `DEPTH`, 8: FIFO entries; power of 2, minimum 4.
- `PC_RESET`, 32'h0000_0000: PC of the first bundle after reset.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: descriptor valid.
- `in_ready` out 1: descriptor accepted when high together with `in_valid`.
- `in_op` in 17: operation id, `{func7, func3, opcode}`.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_imm` in 32: signed immediate or offset, in bytes.
- `drain` in 1: permits emitting a partial bundle.
- `flush` in 1: discards all buffered state.
- `flush_pc` in 32: new PC loaded on `flush`.
- `out_valid` out 1: bundle valid.
- `out_ready` in 1: bundle consumed.
- `out_instr` out 96: lane0 in [31:0], lane1 in [63:32], lane2 in [95:64].
- `out_lane_valid` out 3: per-lane valid, always contiguous from lane0.
- `out_pc` out 32: PC of lane0.
- `err_illegal` out 1: one-cycle pulse when a descriptor is dropped.
- `illegal_cnt` out 8: count of dropped descriptors, saturating.

## Operation
- Stage E (encode register) holds one encoded word and a valid bit. It is followed by the FIFO, then the bundler.
- Encoding is selected by `in_op[6:0]`:
  - 0110011 (R-type): {f7, rs2, rs1, f3, rd, op}.
  - 0010011, 0000011, and 1100111 with f3=000 (I-type): {imm[11:0], rs1, f3, rd, op}.
  - 0100011 (S-type): {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - 1100011 (B-type): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - 1101111 (J-type): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- For I, S, B and J types, `in_op[16:10]` must be 0; the func7 bits of the instruction come from the immediate.
- Illegal descriptors are not written to the FIFO. They raise `err_illegal` and increment `illegal_cnt`. A descriptor is illegal when:
  - it has any other opcode;
  - it is 0010011 with f3=001 or f3=101 (shifts are not encoded);
  - it is R-type with f7 not in {0000000, 0100000, 0000001};
  - it is 0100000 with f3 not in {000, 101}.
- Bundler:
  - `out_valid`=1 when FIFO count ≥3, or when count ≥1 and `drain`=1.
  - Lanes are filled from the FIFO head.
  - `out_lane_valid` is 3'b111, 3'b011 or 3'b001.
- On an output handshake, pop n = popcount(`out_lane_valid`) entries and set `out_pc` += 4·n.
- `flush`:
  - next cycle, E and the FIFO are empty and `out_pc` = `flush_pc`;
  - an input or output handshake in the same cycle is discarded;
  - `illegal_cnt` is kept.
- Reset values: `in_ready`=1 (combinational), `out_valid`=0, `out_lane_valid`=0, `out_instr`=0, `out_pc`=`PC_RESET`, `err_illegal`=0, `illegal_cnt`=0.

## Timing
- An input handshake in cycle t loads E at edge t+1. The word is written to the FIFO at edge t+2 if the descriptor is legal; `err_illegal` is high during cycle t+1 if it is not.
- `in_ready` = (count + E.valid) < DEPTH, so E never stalls.
- `out_*` is driven combinationally from the FIFO head, so `out_valid` can rise in cycle t+2.
- While `out_valid`=1 and `out_ready`=0, `out_instr`, `out_lane_valid` and `out_pc` stay stable. The one exception: lane count may grow while `drain`=1 and new entries arrive.
- A FIFO write and a pop in the same cycle are both performed; count changes by +1−n. Pointers wrap modulo DEPTH.
- Full: `in_ready`=0 and no entry is overwritten.
- Empty with `drain`=1: `out_valid`=0.
- `illegal_cnt` holds at 255.
- `rst_n`=0 mid-stream: all entries are lost and all outputs take their reset values at the next edge.

## Configuration
- `ENCODER_IMM_RANGE_CHECK_EN` defined: a descriptor is illegal (dropped, `err_illegal` pulses) when:
  - I/S `in_imm` is outside [−2048, 2047];
  - B `in_imm` is outside [−4096, 4094] or odd;
  - J `in_imm` is outside [−2^20, 2^20−2] or odd.
- Undefined: immediates are truncated to the field bits with no error.

## Test plan
- ADD x3,x1,x2 (op 0000000_000_0110011), then ADDI x1,x0,5, then SW x2,8(x1) -> one bundle: lane words 0x002081B3, 0x00500093, 0x0020A423; `out_pc`=0x0; next `out_pc`=0xC.
- BEQ x1,x2,+8 and JAL x1,+16, then `drain`=1 -> bundle 0x00208463, 0x010000EF; `out_lane_valid`=3'b011; following `out_pc` +8.
- Op 0000000_000_1110011 -> `err_illegal` pulses for 1 cycle, `illegal_cnt`=1, no FIFO write. With the macro defined, ADDI imm=4096 is also dropped; without it the bench sees 0x00000093 (rd=1, rs1=0).
- `out_ready`=0 with DEPTH+1 descriptors offered -> `in_ready` falls after DEPTH accepted; `out_*` is stable; no entry is lost once `out_ready` rises.
- `flush` with `flush_pc`=0x100 while 5 entries are buffered -> next cycle `out_valid`=0; the next 3 descriptors emit with `out_pc`=0x100.
- `rst_n`=0 for one cycle mid-bundle -> all outputs take reset values and `out_pc`=`PC_RESET`.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes decoder-format operation descriptors into RV32IM words, buffers them in
// a FIFO and emits 3-wide fetch bundles with a running PC. Optional: ENCODER_IMM_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] out_instr,
  output logic [2:0]  out_lane_valid,
  output logic [31:0] out_pc,
  output logic        err_illegal,
  output logic [7:0]  illegal_cnt
);

  // Both ports are valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; out_* stays stable while out_valid is high and out_ready is low.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          e_valid_q, e_valid_d;
  logic [31:0]   e_word_q, e_word_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_zero;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        in_fire;
  logic        mem_we;
  logic [2:0]  lane_valid;
  logic [1:0]  pop_n;
  logic [AW-1:0] rd_ptr1, rd_ptr2;
  logic        imm_i_ok, imm_b_ok, imm_j_ok;

  assign opc     = in_op[6:0];
  assign f3      = in_op[9:7];
  assign f7      = in_op[16:10];
  assign f7_zero = (f7 == 7'b0000000);

`ifdef ENCODER_IMM_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s    = $signed(in_imm);
  assign imm_i_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign imm_b_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
  assign imm_j_ok = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];
`else
  // Immediates are silently truncated to their field bits.
  logic unused_imm;
  assign unused_imm = ^in_imm[31:21];
  assign imm_i_ok   = 1'b1;
  assign imm_b_ok   = 1'b1;
  assign imm_j_ok   = 1'b1;
`endif

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (opc)
      7'b0110011: begin
        enc_word  = {f7, in_rs2, in_rs1, f3, in_rd, opc};
        enc_legal = f7_zero || (f7 == 7'b0000001) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      7'b0010011: begin
        enc_word  = {in_imm[11:0], in_rs1, f3, in_rd, opc};
        enc_legal = f7_zero && (f3 != 3'b001) && (f3 != 3'b101) && imm_i_ok;
      end
      7'b0000011: begin
        enc_word  = {in_imm[11:0], in_rs1, f3, in_rd, opc};
        enc_legal = f7_zero && imm_i_ok;
      end
      7'b1100111: begin
        enc_word  = {in_imm[11:0], in_rs1, f3, in_rd, opc};
        enc_legal = f7_zero && (f3 == 3'b000) && imm_i_ok;
      end
      7'b0100011: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
        enc_legal = f7_zero && imm_i_ok;
      end
      7'b1100011: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
        enc_legal = f7_zero && imm_b_ok;
      end
      7'b1101111: begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
        enc_legal = f7_zero && imm_j_ok;
      end
      default: ;
    endcase
  end

  // E only holds legal words; counting it here guarantees its FIFO write always has room.
  assign in_ready = (count_q + CW'(e_valid_q)) < DEPTH_C;
  assign in_fire  = in_valid && in_ready && !flush;

  always_comb begin
    lane_valid = 3'b000;
    if (count_q >= CW'(3))                  lane_valid = 3'b111;
    else if (drain && (count_q == CW'(2))) lane_valid = 3'b011;
    else if (drain && (count_q == CW'(1))) lane_valid = 3'b001;
  end

  assign rd_ptr1        = rd_ptr_q + AW'(1);
  assign rd_ptr2        = rd_ptr_q + AW'(2);
  assign out_valid      = |lane_valid;
  assign out_lane_valid = lane_valid;
  assign out_instr      = {lane_valid[2] ? mem_q[rd_ptr2]  : 32'h0,
                           lane_valid[1] ? mem_q[rd_ptr1]  : 32'h0,
                           lane_valid[0] ? mem_q[rd_ptr_q] : 32'h0};
  assign out_pc         = pc_q;
  assign err_illegal    = err_q;
  assign illegal_cnt    = cnt_q;
  assign pop_n          = (out_valid && out_ready) ?
                          (2'(lane_valid[0]) + 2'(lane_valid[1]) + 2'(lane_valid[2])) : 2'd0;
  assign mem_we         = e_valid_q && !flush && rst_n;

  always_comb begin
    e_valid_d = in_fire && enc_legal;
    e_word_d  = in_fire ? enc_word : e_word_q;
    err_d     = in_fire && !enc_legal;
    cnt_d     = (err_d && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
    wr_ptr_d  = wr_ptr_q + AW'(e_valid_q);
    rd_ptr_d  = rd_ptr_q + AW'(pop_n);
    count_d   = count_q + CW'(e_valid_q) - CW'(pop_n);
    pc_d      = pc_q + {28'h0, pop_n, 2'b00};
    // Flush wins over any same-cycle handshake; the illegal counter survives it.
    if (flush) begin
      e_valid_d = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      pc_d      = flush_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_valid_q <= 1'b0;
      e_word_q  <= 32'h0;
      err_q     <= 1'b0;
      cnt_q     <= 8'h0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pc_q      <= PC_RESET;
    end else begin
      e_valid_q <= e_valid_d;
      e_word_q  <= e_word_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= e_word_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: encoding, bundling, drain, illegal drops, full, flush, reset.
module tb_instr_encoder;

  localparam int DEPTH = 8;
  localparam logic [16:0] OP_ADD   = 17'b0000000_000_0110011;
  localparam logic [16:0] OP_SUB   = 17'b0100000_000_0110011;
  localparam logic [16:0] OP_BADR  = 17'b0100000_001_0110011;
  localparam logic [16:0] OP_ADDI  = 17'b0000000_000_0010011;
  localparam logic [16:0] OP_SLLI  = 17'b0000000_001_0010011;
  localparam logic [16:0] OP_SW    = 17'b0000000_010_0100011;
  localparam logic [16:0] OP_BEQ   = 17'b0000000_000_1100011;
  localparam logic [16:0] OP_JAL   = 17'b0000000_000_1101111;
  localparam logic [16:0] OP_ECALL = 17'b0000000_000_1110011;

  logic        clk, rst_n, in_valid, in_ready, drain, flush, out_valid, out_ready, err_illegal;
  logic [16:0] in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, flush_pc, out_pc;
  logic [95:0] out_instr;
  logic [2:0]  out_lane_valid;
  logic [7:0]  illegal_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];

  instr_encoder #(.DEPTH(DEPTH), .PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .drain(drain),
    .flush(flush), .flush_pc(flush_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_lane_valid(out_lane_valid), .out_pc(out_pc),
    .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic send(input logic [16:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; drain = 1'b0; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_lane_valid !== 3'b000) begin errors++; $display("FAIL reset_lane_valid: got %b expected 000", out_lane_valid); end
    checks++; if (out_instr !== 96'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_illegal); end
    checks++; if (illegal_cnt !== 8'h0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", illegal_cnt); end
    rst_n = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic test_bundle3();
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    send(OP_SW, 5'd0, 5'd1, 5'd2, 32'd8);
    idle(1);
    for (int i = 0; i < 8 && out_valid !== 1'b1; i++) idle(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b3_valid: got %b expected 1", out_valid); end
    checks++; if (out_lane_valid !== 3'b111) begin errors++; $display("FAIL b3_lanes: got %b expected 111", out_lane_valid); end
    checks++; if (out_instr !== {32'h0020A423, 32'h00500093, 32'h002081B3}) begin errors++; $display("FAIL b3_words: got %h expected 0020a42300500093002081b3", out_instr); end
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL b3_pc: got %h expected %h", out_pc, exp_pc); end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    exp_pc = 32'hC;
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL b3_next_pc: got %h expected %h", out_pc, exp_pc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b3_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_drain();
    send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8);
    send(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd16);
    idle(4);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dr_hold: got %b expected 0", out_valid); end
    drain = 1'b1;
    #1;
    checks++; if (out_lane_valid !== 3'b011) begin errors++; $display("FAIL dr_lanes: got %b expected 011", out_lane_valid); end
    checks++; if (out_instr[63:0] !== {32'h010000EF, 32'h00208463}) begin errors++; $display("FAIL dr_words: got %h expected 010000ef00208463", out_instr[63:0]); end
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL dr_pc: got %h expected %h", out_pc, exp_pc); end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    exp_pc = exp_pc + 32'd8;
    #1;
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL dr_next_pc: got %h expected %h", out_pc, exp_pc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dr_empty_drain: got %b expected 0", out_valid); end
    drain = 1'b0;
  endtask

  task automatic test_illegal();
    send(OP_ECALL, 5'd0, 5'd0, 5'd0, 32'd0);
    idle(1);
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL il_pulse: got %b expected 1", err_illegal); end
    checks++; if (illegal_cnt !== 8'd1) begin errors++; $display("FAIL il_cnt1: got %0d expected 1", illegal_cnt); end
    idle(1);
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL il_pulse_end: got %b expected 0", err_illegal); end
    send(OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd1);
    idle(1);
    checks++; if (illegal_cnt !== 8'd2) begin errors++; $display("FAIL il_shift: got %0d expected 2", illegal_cnt); end
    send(OP_BADR, 5'd3, 5'd1, 5'd2, 32'd0);
    idle(1);
    checks++; if (illegal_cnt !== 8'd3) begin errors++; $display("FAIL il_f7f3: got %0d expected 3", illegal_cnt); end
    drain = 1'b1;
    idle(2);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL il_no_write: got %b expected 0", out_valid); end
    drain = 1'b0;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd4096);
    send(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
    idle(3);
    drain = 1'b1;
    #1;
`ifdef ENCODER_IMM_RANGE_CHECK_EN
    checks++; if (illegal_cnt !== 8'd4) begin errors++; $display("FAIL il_imm_cnt: got %0d expected 4", illegal_cnt); end
    checks++; if (out_lane_valid !== 3'b001) begin errors++; $display("FAIL il_imm_lanes: got %b expected 001", out_lane_valid); end
    checks++; if (out_instr[31:0] !== 32'h402081B3) begin errors++; $display("FAIL il_sub_word: got %h expected 402081b3", out_instr[31:0]); end
`else
    checks++; if (illegal_cnt !== 8'd3) begin errors++; $display("FAIL il_imm_cnt: got %0d expected 3", illegal_cnt); end
    checks++; if (out_lane_valid !== 3'b011) begin errors++; $display("FAIL il_imm_lanes: got %b expected 011", out_lane_valid); end
    checks++; if (out_instr[63:0] !== {32'h402081B3, 32'h00000093}) begin errors++; $display("FAIL il_trunc_words: got %h expected 402081b300000093", out_instr[63:0]); end
`endif
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL il_pc: got %h expected %h", out_pc, exp_pc); end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    drain = 1'b0;
`ifdef ENCODER_IMM_RANGE_CHECK_EN
    exp_pc = exp_pc + 32'd4;
`else
    exp_pc = exp_pc + 32'd8;
`endif
    #1;
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL il_next_pc: got %h expected %h", out_pc, exp_pc); end
  endtask

  task automatic test_full();
    int accepted;
    int n;
    logic [95:0] snap;
    logic snap_taken;
    logic [31:0] got, exp_w;
    accepted = 0; snap = '0; snap_taken = 1'b0;
    exp_q.delete();
    out_ready = 1'b0; drain = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (out_valid && !snap_taken) begin snap = out_instr; snap_taken = 1'b1; end
      if (in_ready && accepted < DEPTH + 1) begin
        in_valid = 1'b1; in_op = OP_ADDI; in_rd = 5'(accepted + 1); in_rs1 = 5'd0;
        in_rs2 = 5'd0; in_imm = 32'(accepted + 1);
        exp_q.push_back(addi_word(5'(accepted + 1), 12'(accepted + 1)));
        accepted++;
      end else begin
        in_valid = 1'b0;
      end
    end
    idle(1);
    checks++; if (accepted != DEPTH) begin errors++; $display("FAIL full_accepted: got %0d expected %0d", accepted, DEPTH); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_lane_valid !== 3'b111) begin errors++; $display("FAIL full_lanes: got %b expected 111", out_lane_valid); end
    checks++; if (out_instr !== snap) begin errors++; $display("FAIL full_stable: got %h expected %h", out_instr, snap); end
    checks++; if (out_instr !== {exp_q[2], exp_q[1], exp_q[0]}) begin errors++; $display("FAIL full_head: got %h expected %h", out_instr, {exp_q[2], exp_q[1], exp_q[0]}); end
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL full_pc_hold: got %h expected %h", out_pc, exp_pc); end
    out_ready = 1'b1; drain = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        n = 0;
        for (int l = 0; l < 3; l++) begin
          if (out_lane_valid[l] && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got = out_instr[l*32 +: 32];
            checks++; if (got !== exp_w) begin errors++; $display("FAIL full_lane%0d: got %h expected %h", l, got, exp_w); end
            n++;
          end
        end
        checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL full_drain_pc: got %h expected %h", out_pc, exp_pc); end
        exp_pc = exp_pc + 32'(4 * n);
      end
      @(negedge clk);
    end
    out_ready = 1'b0; drain = 1'b0;
    #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_timeout: got %0d left expected 0", exp_q.size()); end
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL full_end_pc: got %h expected %h", out_pc, exp_pc); end
  endtask

  task automatic test_back_to_back();
    int sent;
    int n;
    logic [31:0] got, exp_w;
    sent = 0;
    exp_q.delete();
    out_ready = 1'b1; drain = 1'b0;
    for (int c = 0; c < 30 && (sent < 6 || exp_q.size() > 0); c++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        n = 0;
        for (int l = 0; l < 3; l++) begin
          if (out_lane_valid[l] && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            got = out_instr[l*32 +: 32];
            checks++; if (got !== exp_w) begin errors++; $display("FAIL b2b_lane%0d: got %h expected %h", l, got, exp_w); end
            n++;
          end
        end
        checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL b2b_pc: got %h expected %h", out_pc, exp_pc); end
        exp_pc = exp_pc + 32'(4 * n);
      end
      if (sent < 6 && in_ready) begin
        in_valid = 1'b1; in_op = OP_ADDI; in_rd = 5'(sent + 10); in_rs1 = 5'd0;
        in_rs2 = 5'd0; in_imm = 32'(sent + 20);
        exp_q.push_back(addi_word(5'(sent + 10), 12'(sent + 20)));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    idle(1);
    out_ready = 1'b0;
    checks++; if (exp_q.size() != 0 || sent != 6) begin errors++; $display("FAIL b2b_timeout: got %0d left expected 0", exp_q.size()); end
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL b2b_end_pc: got %h expected %h", out_pc, exp_pc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; drain = 1'b0;
    for (int i = 0; i < 5; i++) send(OP_ADDI, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1));
    idle(3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fl_pre_valid: got %b expected 1", out_valid); end
    flush = 1'b1; flush_pc = 32'h100; out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_ADDI; in_rd = 5'd9; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd9;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL fl_pc: got %h expected 00000100", out_pc); end
    drain = 1'b1;
    idle(2);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_input_dropped: got %b expected 0", out_valid); end
    drain = 1'b0;
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    send(OP_SW, 5'd0, 5'd1, 5'd2, 32'd8);
    idle(1);
    for (int i = 0; i < 8 && out_valid !== 1'b1; i++) idle(1);
    checks++; if (out_instr !== {32'h0020A423, 32'h00500093, 32'h002081B3}) begin errors++; $display("FAIL fl_words: got %h expected 0020a42300500093002081b3", out_instr); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL fl_bundle_pc: got %h expected 00000100", out_pc); end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    exp_pc = 32'h10C;
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL fl_next_pc: got %h expected %h", out_pc, exp_pc); end
  endtask

  task automatic test_reset_mid();
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    send(OP_SW, 5'd0, 5'd1, 5'd2, 32'd8);
    idle(1);
    for (int i = 0; i < 8 && out_valid !== 1'b1; i++) idle(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b expected 1", out_valid); end
    send(OP_ECALL, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
    checks++; if (out_lane_valid !== 3'b000) begin errors++; $display("FAIL rm_lanes: got %b expected 000", out_lane_valid); end
    checks++; if (out_instr !== 96'h0) begin errors++; $display("FAIL rm_instr: got %h expected 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rm_pc: got %h expected 0", out_pc); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL rm_err: got %b expected 0", err_illegal); end
    checks++; if (illegal_cnt !== 8'h0) begin errors++; $display("FAIL rm_cnt: got %0d expected 0", illegal_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    drain = 1'b1;
    idle(2);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_lost: got %b expected 0", out_valid); end
    drain = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bundle3();
    test_drain();
    test_illegal();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
